// File: rtl/apu_mix_scheduler.sv
// APU mixer sequencer: one shared 8x8 multiplier scales pulse, triangle and
// noise in turn, accumulates the results with DMC and emits one saturated
// 8-bit sample with a one-cycle valid strobe.
module apu_mix_scheduler #(
  parameter int unsigned MUL_LATENCY = 0,
  parameter logic [7:0]  K_PULSE     = 8'd144,
  parameter logic [7:0]  K_TRI       = 8'd162,
  parameter logic [7:0]  K_NOISE     = 8'd94
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_tick,
  input  logic [3:0]  chan_en,
  input  logic [3:0]  from_pulse1,
  input  logic [3:0]  from_pulse2,
  input  logic [3:0]  from_triangle,
  input  logic [3:0]  from_noise,
  input  logic [6:0]  from_dmc,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic [15:0] mul_p,
  output logic [7:0]  sample_out,
  output logic        sample_valid,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_OP_PULSE = 3'd1,
    S_OP_TRI   = 3'd2,
    S_OP_NOISE = 3'd3,
    S_SUM      = 3'd4
  } state_e;

  // Final cycle index within an OP state (each OP lasts 1+MUL_LATENCY cycles).
  localparam logic [1:0] LAST_CNT = 2'(MUL_LATENCY);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [4:0]  pulse_sum_q, pulse_sum_d;
  logic [3:0]  tri_q, tri_d;
  logic [3:0]  noise_q, noise_d;
  logic [6:0]  dmc_q, dmc_d;
  logic [8:0]  acc_q, acc_d;
  logic [7:0]  sample_q, sample_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        overrun_q, overrun_d;
  logic [7:0]  mul_a_q, mul_a_d;
  logic [7:0]  mul_b_q, mul_b_d;
  logic        op_last;
  logic        unused_mul_p;

  // Product bits outside the per-channel truncation windows are never used.
  assign unused_mul_p = ^{mul_p[15:13], mul_p[5:0]};

  // Clamp the final sum to the 8-bit DAC range.
  function automatic logic [7:0] sat8(input logic [9:0] v);
    if (v > 10'd255) begin
      return 8'hFF;
    end else begin
      return v[7:0];
    end
  endfunction

  assign op_last = (cnt_q == LAST_CNT);

  // Next-state, operand latching, accumulation and output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pulse_sum_d = pulse_sum_q;
    tri_d       = tri_q;
    noise_d     = noise_q;
    dmc_d       = dmc_q;
    acc_d       = acc_q;
    sample_d    = sample_q;
    valid_d     = 1'b0;
    overrun_d   = overrun_q;
    mul_a_d     = 8'd0;
    mul_b_d     = 8'd0;

    // A tick arriving anywhere outside IDLE (SUM included) is dropped but remembered.
    if (sample_tick && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end

    case (state_q)
      S_IDLE: begin
        if (sample_tick) begin
          pulse_sum_d = {1'b0, from_pulse1 & {4{chan_en[0]}}}
                      + {1'b0, from_pulse2 & {4{chan_en[1]}}};
          tri_d       = from_triangle & {4{chan_en[2]}};
          noise_d     = from_noise & {4{chan_en[3]}};
          dmc_d       = from_dmc;
          acc_d       = 9'd0;
          cnt_d       = 2'd0;
          state_d     = S_OP_PULSE;
        end else begin
          state_d     = S_IDLE;
        end
      end
      S_OP_PULSE: begin
        if (op_last) begin
          acc_d   = acc_q + {2'b00, mul_p[12:6]};
          cnt_d   = 2'd0;
          state_d = S_OP_TRI;
        end else begin
          cnt_d   = cnt_q + 2'd1;
        end
      end
      S_OP_TRI: begin
        if (op_last) begin
          acc_d   = acc_q + {3'b000, mul_p[11:6]};
          cnt_d   = 2'd0;
          state_d = S_OP_NOISE;
        end else begin
          cnt_d   = cnt_q + 2'd1;
        end
      end
      S_OP_NOISE: begin
        if (op_last) begin
          acc_d   = acc_q + {4'b0000, mul_p[10:6]};
          cnt_d   = 2'd0;
          state_d = S_SUM;
        end else begin
          cnt_d   = cnt_q + 2'd1;
        end
      end
      S_SUM: begin
        sample_d = sat8({1'b0, acc_q} + {3'b000, dmc_q});
        valid_d  = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Operands are registered from the next state so they are stable for the whole OP state.
    case (state_d)
      S_OP_PULSE: begin
        mul_a_d = {3'b000, pulse_sum_d};
        mul_b_d = K_PULSE;
      end
      S_OP_TRI: begin
        mul_a_d = {4'b0000, tri_d};
        mul_b_d = K_TRI;
      end
      S_OP_NOISE: begin
        mul_a_d = {4'b0000, noise_d};
        mul_b_d = K_NOISE;
      end
      default: begin
        mul_a_d = 8'd0;
        mul_b_d = 8'd0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 2'd0;
      pulse_sum_q <= 5'd0;
      tri_q       <= 4'd0;
      noise_q     <= 4'd0;
      dmc_q       <= 7'd0;
      acc_q       <= 9'd0;
      sample_q    <= 8'd0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      mul_a_q     <= 8'd0;
      mul_b_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pulse_sum_q <= pulse_sum_d;
      tri_q       <= tri_d;
      noise_q     <= noise_d;
      dmc_q       <= dmc_d;
      acc_q       <= acc_d;
      sample_q    <= sample_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
    end
  end

  assign mul_a        = mul_a_q;
  assign mul_b        = mul_b_q;
  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;

endmodule
